// File: rtl/ifstage_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding req/ack fetches
// and hands each word to decode through a valid/ready IF/ID register.
module ifstage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  output logic              IMem_Req,
  output logic [ADDR_W-1:0] IMem_Addr,
  input  logic              IMem_Ack,
  input  logic [31:0]       IMem_Data,
  output logic [31:0]       Instr,
  output logic [31:0]       PC_out,
  output logic              Instr_Valid,
  input  logic              ID_Ready,
  input  logic              PC_sel,
  input  logic [31:0]       Immed,
  input  logic              Redir_En,
  input  logic [31:0]       Redir_PC
);

  typedef enum logic [1:0] {S_RST, S_FETCH, S_VALID, S_DISCARD} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pcout_q, pcout_d;
  logic              vld_q, vld_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [31:0] redir_pc;
  logic [31:0] seq_pc;
  logic        ack;
  logic        drop_req;

  assign redir_pc = Redir_PC & ~32'h3;
  assign seq_pc   = (pcout_q + 32'd4 + (PC_sel ? Immed : 32'd0)) & ~32'h3;
  // An ack only counts while our request is actually on the bus.
  assign ack      = IMem_Ack & req_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcout_d  = pcout_q;
    vld_d    = vld_q;
    addr_d   = addr_q;
    drop_req = 1'b0;
    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
        if (Redir_En) pc_d = redir_pc;
      end
      S_FETCH: begin
        if (Redir_En) begin
          pc_d = redir_pc;
          // Ack in the redirect cycle retires the old request, so drop Req
          // for a cycle and reissue; otherwise the stale ack must be drained.
          if (ack) drop_req = 1'b1;
          else if (req_q) state_d = S_DISCARD;
        end else if (ack) begin
          instr_d = IMem_Data;
          pcout_d = pc_q;
          vld_d   = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (Redir_En) begin
          vld_d   = 1'b0;
          pc_d    = redir_pc;
          state_d = S_FETCH;
        end else if (ID_Ready) begin
          vld_d   = 1'b0;
          pc_d    = seq_pc;
          state_d = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (Redir_En) pc_d = redir_pc;
        if (ack) state_d = S_FETCH;
      end
      default: state_d = S_RST;
    endcase
    req_d = ((state_d == S_FETCH) && !drop_req) || (state_d == S_DISCARD);
    // The outstanding address stays put while the stale request drains.
    if (state_d != S_DISCARD) addr_d = pc_d[ADDR_W+1:2];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pcout_q <= 32'd0;
      vld_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC[ADDR_W+1:2];
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcout_q <= pcout_d;
      vld_q   <= vld_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign IMem_Req    = req_q;
  assign IMem_Addr   = addr_q;
  assign Instr       = instr_q;
  assign PC_out      = pcout_q;
  assign Instr_Valid = vld_q;

endmodule

// File: tb/tb_ifstage_fetch.sv
// Directed bench for ifstage_fetch: inputs driven and outputs checked on the falling edge.
module tb_ifstage_fetch;

  localparam int ADDR_W = 10;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b1;
  logic              IMem_Req;
  logic [ADDR_W-1:0] IMem_Addr;
  logic              IMem_Ack = 1'b0;
  logic [31:0]       IMem_Data = 32'd0;
  logic [31:0]       Instr;
  logic [31:0]       PC_out;
  logic              Instr_Valid;
  logic              ID_Ready = 1'b0;
  logic              PC_sel = 1'b0;
  logic [31:0]       Immed = 32'd0;
  logic              Redir_En = 1'b0;
  logic [31:0]       Redir_PC = 32'd0;

  int total = 0;
  int bad   = 0;

  ifstage_fetch #(.RESET_PC(32'h0), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Ack(IMem_Ack), .IMem_Data(IMem_Data),
    .Instr(Instr), .PC_out(PC_out), .Instr_Valid(Instr_Valid), .ID_Ready(ID_Ready),
    .PC_sel(PC_sel), .Immed(Immed), .Redir_En(Redir_En), .Redir_PC(Redir_PC)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  initial begin
    #1 Reset_n = 1'b0;
    step(); step();
    check("rst_req", 32'(IMem_Req), 32'd0);
    check("rst_vld", 32'(Instr_Valid), 32'd0);
    check("rst_instr", Instr, 32'd0);
    check("rst_pcout", PC_out, 32'd0);
    Reset_n = 1'b1;
    step();
    check("t1_req", 32'(IMem_Req), 32'd1);
    check("t1_addr", 32'(IMem_Addr), 32'd0);
    // 1: ack on first request cycle
    IMem_Ack = 1'b1; IMem_Data = 32'hE000_0005;
    step();
    IMem_Ack = 1'b0;
    check("t1_vld", 32'(Instr_Valid), 32'd1);
    check("t1_instr", Instr, 32'hE000_0005);
    check("t1_pcout", PC_out, 32'd0);
    check("t1_req_lo", 32'(IMem_Req), 32'd0);
    // 2: stall three cycles, a stray ack in the middle is ignored
    step();
    check("t2_hold_instr0", Instr, 32'hE000_0005);
    IMem_Ack = 1'b1; IMem_Data = 32'h0000_0099;
    step();
    IMem_Ack = 1'b0;
    check("t2_stray_ack", Instr, 32'hE000_0005);
    check("t2_hold_req", 32'(IMem_Req), 32'd0);
    step();
    check("t2_hold_vld", 32'(Instr_Valid), 32'd1);
    check("t2_hold_pcout", PC_out, 32'd0);
    ID_Ready = 1'b1;
    step();
    ID_Ready = 1'b0;
    check("t2_req", 32'(IMem_Req), 32'd1);
    check("t2_addr", 32'(IMem_Addr), 32'd1);
    check("t2_vld", 32'(Instr_Valid), 32'd0);
    // 3: forward branch to 0x10, then backward branch to 0x0C
    IMem_Ack = 1'b1; IMem_Data = 32'h2222_2222;
    step();
    IMem_Ack = 1'b0;
    check("t3_pcout4", PC_out, 32'h4);
    ID_Ready = 1'b1; PC_sel = 1'b1; Immed = 32'h8;
    step();
    ID_Ready = 1'b0;
    check("t3_addr4", 32'(IMem_Addr), 32'h4);
    IMem_Ack = 1'b1; IMem_Data = 32'h3333_3333;
    step();
    IMem_Ack = 1'b0;
    check("t3_pcout10", PC_out, 32'h10);
    ID_Ready = 1'b1; PC_sel = 1'b1; Immed = 32'hFFFF_FFF8;
    step();
    ID_Ready = 1'b0; PC_sel = 1'b0; Immed = 32'd0;
    check("t3_addr3", 32'(IMem_Addr), 32'h3);
    check("t3_req", 32'(IMem_Req), 32'd1);
    // 4: redirect while fetching, stale ack three cycles later
    Redir_En = 1'b1; Redir_PC = 32'h40;
    step();
    Redir_En = 1'b0;
    check("t4_disc_addr", 32'(IMem_Addr), 32'h3);
    check("t4_disc_req", 32'(IMem_Req), 32'd1);
    step();
    check("t4_disc_vld0", 32'(Instr_Valid), 32'd0);
    step();
    IMem_Ack = 1'b1; IMem_Data = 32'hDEAD_BEEF;
    step();
    IMem_Ack = 1'b0;
    check("t4_drop_vld", 32'(Instr_Valid), 32'd0);
    check("t4_reissue_addr", 32'(IMem_Addr), 32'h10);
    check("t4_reissue_req", 32'(IMem_Req), 32'd1);
    IMem_Ack = 1'b1; IMem_Data = 32'h1111_1111;
    step();
    IMem_Ack = 1'b0;
    check("t4_vld", 32'(Instr_Valid), 32'd1);
    check("t4_instr", Instr, 32'h1111_1111);
    check("t4_pcout", PC_out, 32'h40);
    // redirect coinciding with ack: data dropped, Req low one cycle, low PC bits masked
    ID_Ready = 1'b1;
    step();
    ID_Ready = 1'b0;
    check("ra_addr44", 32'(IMem_Addr), 32'h11);
    IMem_Ack = 1'b1; IMem_Data = 32'hBAD0_BAD0; Redir_En = 1'b1; Redir_PC = 32'h103;
    step();
    IMem_Ack = 1'b0; Redir_En = 1'b0;
    check("ra_req_gap", 32'(IMem_Req), 32'd0);
    check("ra_vld", 32'(Instr_Valid), 32'd0);
    check("ra_addr", 32'(IMem_Addr), 32'h40);
    step();
    check("ra_req_again", 32'(IMem_Req), 32'd1);
    check("ra_addr_again", 32'(IMem_Addr), 32'h40);
    // 5: two redirects while draining (latest wins), then wrap past 2^32
    Redir_En = 1'b1; Redir_PC = 32'h200;
    step();
    Redir_PC = 32'hFFFF_FFFC;
    step();
    Redir_En = 1'b0;
    check("t5_disc_addr", 32'(IMem_Addr), 32'h40);
    check("t5_disc_req", 32'(IMem_Req), 32'd1);
    IMem_Ack = 1'b1; IMem_Data = 32'hCAFE_F00D;
    step();
    check("t5_addr_top", 32'(IMem_Addr), 32'h3FF);
    step();
    IMem_Ack = 1'b0;
    check("t5_pcout", PC_out, 32'hFFFF_FFFC);
    check("t5_instr", Instr, 32'hCAFE_F00D);
    ID_Ready = 1'b1; PC_sel = 1'b0;
    step();
    ID_Ready = 1'b0;
    check("t5_wrap_addr", 32'(IMem_Addr), 32'd0);
    check("t5_wrap_req", 32'(IMem_Req), 32'd1);
    check("t5_wrap_vld", 32'(Instr_Valid), 32'd0);
    // 6: asynchronous reset in the middle of a fetch
    #2 Reset_n = 1'b0;
    #1;
    check("t6_req", 32'(IMem_Req), 32'd0);
    check("t6_vld", 32'(Instr_Valid), 32'd0);
    check("t6_instr", Instr, 32'd0);
    check("t6_pcout", PC_out, 32'd0);
    step();
    Reset_n = 1'b1;
    step();
    check("t6_refetch_req", 32'(IMem_Req), 32'd1);
    check("t6_refetch_addr", 32'(IMem_Addr), 32'd0);
    IMem_Ack = 1'b1; IMem_Data = 32'h0BAD_CAFE;
    step();
    IMem_Ack = 1'b0;
    check("t6_instr_after", Instr, 32'h0BAD_CAFE);
    check("t6_vld_after", 32'(Instr_Valid), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
